// File: rtl/store_sched_pkg.sv
// ============================================================================
// Module   : store_sched_pkg
// Purpose  : Shared store-queue configuration: lengths, IO field, depth, FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_sched_pkg;

  localparam int          c_STQ_DEPTH_DEF = 4;
  localparam logic [2:0]  c_LEN_B         = 3'd1;
  localparam logic [2:0]  c_LEN_H         = 3'd2;
  localparam logic [2:0]  c_LEN_W         = 3'd4;
  localparam logic [1:0]  c_IO_FIELD      = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_IO_WAIT = 2'd2
  } state_t;

  // Anything that is not a byte or halfword access is a word access.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    if (len == c_LEN_B)      return c_LEN_B;
    else if (len == c_LEN_H) return c_LEN_H;
    else                     return c_LEN_W;
  endfunction

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == c_IO_FIELD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_sched_if.sv
// ============================================================================
// Module   : store_sched_if
// Purpose  : Store enqueue, load check and RAM byte-write signals of store_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface store_sched_if;

  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_len;
  logic        st_ready;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic [2:0]  ld_len;
  logic        ld_conflict;
  logic        rd_busy;
  logic        io_buffer_full;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_grant;
  logic        empty;
  logic [3:0]  count;

  modport master (
    output st_valid, st_addr, st_data, st_len, ld_check, ld_addr, ld_len,
           rd_busy, io_buffer_full, wr_grant,
    input  st_ready, ld_conflict, wr_req, wr_addr, wr_data, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_len, ld_check, ld_addr, ld_len,
           rd_busy, io_buffer_full, wr_grant,
    output st_ready, ld_conflict, wr_req, wr_addr, wr_data, empty, count
  );

endinterface

`default_nettype wire

// File: rtl/store_sched_stq_overlap.sv
// ============================================================================
// Module   : stq_overlap
// Purpose  : Overlap test between one queued store's remaining bytes and a load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stq_overlap (
  input  wire logic        i_valid,
  input  wire logic [31:0] i_st_start,
  input  wire logic [32:0] i_st_end,
  input  wire logic [31:0] i_ld_start,
  input  wire logic [32:0] i_ld_end,
  output      logic        o_hit
);

  // Half-open ranges; 33-bit ends keep the compare free of wrap-around.
  assign o_hit = i_valid
              && ({1'b0, i_st_start} < i_ld_end)
              && ({1'b0, i_ld_start} < i_st_end);

endmodule

`default_nettype wire

// File: rtl/store_sched.sv
// ============================================================================
// Module   : store_sched
// Purpose  : Store queue draining one byte per RAM grant, with IO pacing.
//            Define LOAD_CONFLICT_EN for exact load/store overlap detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_sched
  import store_sched_pkg::*;
#(
  parameter int STQ_DEPTH = c_STQ_DEPTH_DEF
) (
  input  wire logic  clk,
  input  wire logic  rst,
  store_sched_if.slave bus
);

  localparam int         c_PTR_W = $clog2(STQ_DEPTH);
  localparam logic [3:0] c_DEPTH = 4'(STQ_DEPTH);

  logic [31:0]        r_addr [STQ_DEPTH];
  logic [31:0]        r_data [STQ_DEPTH];
  logic [2:0]         r_len  [STQ_DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [3:0]         r_count;
  logic [1:0]         r_idx;
  state_t             r_state;

  logic [31:0] w_wr_addr;
  logic [7:0]  w_wr_data;
  logic        w_io;
  logic        w_wr_req;
  logic        w_grant;
  logic        w_last;
  logic        w_pop;
  logic        w_push;
  logic        w_st_ready;
  logic [3:0]  w_count_nxt;

  assign w_wr_addr   = r_addr[r_head] + {30'd0, r_idx};
  assign w_wr_data   = 8'(r_data[r_head] >> {r_idx, 3'b000});
  assign w_io        = is_io(w_wr_addr);
  assign w_wr_req    = (r_state == S_DRAIN) && !bus.rd_busy
                    && !(w_io && bus.io_buffer_full);
  assign w_grant     = w_wr_req && bus.wr_grant;
  assign w_last      = ({1'b0, r_idx} == (r_len[r_head] - 3'd1));
  assign w_pop       = w_grant && w_last;
  assign w_st_ready  = (r_count < c_DEPTH);
  assign w_push      = bus.st_valid && w_st_ready;
  assign w_count_nxt = r_count + {3'd0, w_push} - {3'd0, w_pop};

  // Payload storage needs no reset: occupancy is tracked by head/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.st_addr;
      r_data[r_tail] <= bus.st_data;
      r_len[r_tail]  <= norm_len(bus.st_len);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 4'd0;
      r_idx   <= 2'd0;
      r_state <= S_IDLE;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_W'(1);
        r_idx  <= 2'd0;
      end else if (w_grant) begin
        r_idx  <= r_idx + 2'd1;
      end
      r_count <= w_count_nxt;

      case (r_state)
        S_IDLE: begin
          if (w_push) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_grant && w_io)         r_state <= S_IO_WAIT;
          else if (w_count_nxt == 4'd0) r_state <= S_IDLE;
        end
        S_IO_WAIT: begin
          r_state <= (w_count_nxt != 4'd0) ? S_DRAIN : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LOAD_CONFLICT_EN
  logic [STQ_DEPTH-1:0] w_hit;
  logic [32:0]          w_ld_end;

  assign w_ld_end = {1'b0, bus.ld_addr} + 33'(norm_len(bus.ld_len));

  for (genvar gi = 0; gi < STQ_DEPTH; gi++) begin : g_overlap
    logic [c_PTR_W-1:0] w_rel;
    logic               w_valid;
    logic [31:0]        w_start;
    logic [32:0]        w_end;

    // Slot distance from head decides occupancy; the head skips bytes already written.
    assign w_rel   = c_PTR_W'(gi) - r_head;
    assign w_valid = (4'(w_rel) < r_count);
    assign w_start = r_addr[gi] + ((w_rel == '0) ? {30'd0, r_idx} : 32'd0);
    assign w_end   = {1'b0, r_addr[gi]} + 33'(r_len[gi]);

    stq_overlap u_overlap (
      .i_valid    (w_valid),
      .i_st_start (w_start),
      .i_st_end   (w_end),
      .i_ld_start (bus.ld_addr),
      .i_ld_end   (w_ld_end),
      .o_hit      (w_hit[gi])
    );
  end

  assign bus.ld_conflict = bus.ld_check && (|w_hit);
`else
  assign bus.ld_conflict = bus.ld_check && (r_count != 4'd0);
`endif

  assign bus.st_ready = w_st_ready;
  assign bus.wr_req   = w_wr_req;
  assign bus.wr_addr  = w_wr_addr;
  assign bus.wr_data  = w_wr_data;
  assign bus.empty    = (r_count == 4'd0);
  assign bus.count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_store_sched.sv
// ============================================================================
// Module   : tb_store_sched
// Purpose  : Directed and random checks of store_sched against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_sched;

  localparam int c_DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          len;
  } st_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  st_t  mq[$];
  int   mk;
  bit   m_gap;

  store_sched_if bus ();

  store_sched #(.STQ_DEPTH(c_DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    rst                = 1'b0;
    bus.st_valid       = 1'b0;
    bus.st_addr        = 32'd0;
    bus.st_data        = 32'd0;
    bus.st_len         = 3'd4;
    bus.ld_check       = 1'b0;
    bus.ld_addr        = 32'd0;
    bus.ld_len         = 3'd4;
    bus.rd_busy        = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.wr_grant       = 1'b0;
  endtask

  function automatic int len_of(input logic [2:0] l);
    return (l == 3'd1) ? 1 : (l == 3'd2) ? 2 : 4;
  endfunction

  // Compares every output with the model, then applies this cycle's edge to the model.
  task automatic tick();
    int          n;
    logic [31:0] ca;
    logic [7:0]  cd;
    bit          ereq;
    bit          econf;
    bit          g;
    bit          push;
    st_t         e;
    longint      s;
    longint      en;
    longint      ls;
    longint      le;
    #1;
    n  = mq.size();
    ca = 32'd0;
    cd = 8'd0;
    if (n > 0) begin
      ca = mq[0].a + mk;
      cd = 8'(mq[0].d >> (8 * mk));
    end
    ereq = (n > 0) && !m_gap && !bus.rd_busy && !((ca[17:16] == 2'b11) && bus.io_buffer_full);
`ifdef LOAD_CONFLICT_EN
    econf = 1'b0;
    ls = longint'(bus.ld_addr);
    le = ls + len_of(bus.ld_len);
    for (int j = 0; j < n; j++) begin
      s  = longint'(mq[j].a) + ((j == 0) ? mk : 0);
      en = longint'(mq[j].a) + mq[j].len;
      if (s < le && ls < en) econf = 1'b1;
    end
    econf = econf && bus.ld_check;
`else
    s = 0; en = 0; ls = 0; le = 0;
    econf = bus.ld_check && (n > 0);
`endif
    check_eq("wr_req", bus.wr_req, ereq);
    if (ereq) begin
      check_eq("wr_addr", bus.wr_addr, ca);
      check_eq("wr_data", bus.wr_data, cd);
    end
    check_eq("st_ready", bus.st_ready, n < c_DEPTH);
    check_eq("count", bus.count, n);
    check_eq("empty", bus.empty, n == 0);
    check_eq("ld_conflict", bus.ld_conflict, econf);

    if (rst) begin
      mq.delete();
      mk    = 0;
      m_gap = 1'b0;
    end else begin
      g     = ereq && bus.wr_grant;
      push  = bus.st_valid && (n < c_DEPTH);
      m_gap = g && (ca[17:16] == 2'b11);
      if (g) begin
        mk++;
        if (mk == mq[0].len) begin
          void'(mq.pop_front());
          mk = 0;
        end
      end
      if (push) begin
        e.a   = bus.st_addr;
        e.d   = bus.st_data;
        e.len = len_of(bus.st_len);
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_len   = l;
  endtask

  logic [7:0] eb [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    mk       = 0;
    m_gap    = 1'b0;
    clr_in();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state, including load check against an empty queue
    clr_in();
    bus.ld_check = 1'b1;
    #1;
    check_eq("rst_wr_req", bus.wr_req, 1'b0);
    check_eq("rst_st_ready", bus.st_ready, 1'b1);
    check_eq("rst_empty", bus.empty, 1'b1);
    check_eq("rst_count", bus.count, 4'd0);
    check_eq("rst_ld_conflict", bus.ld_conflict, 1'b0);
    tick();

    // Word store drains as four consecutive little-endian bytes
    eb = '{8'h44, 8'h33, 8'h22, 8'h11};
    clr_in(); push_st(32'h100, 32'h11223344, 3'd4); tick();
    for (int k = 0; k < 4; k++) begin
      clr_in(); bus.wr_grant = 1'b1; #1;
      check_eq("sw_req", bus.wr_req, 1'b1);
      check_eq("sw_addr", bus.wr_addr, 32'h100 + k);
      check_eq("sw_data", bus.wr_data, eb[k]);
      tick();
    end
    clr_in(); #1;
    check_eq("sw_empty", bus.empty, 1'b1);
    tick();

    // Fill past depth with no grants
    for (int i = 0; i < 5; i++) begin
      clr_in(); push_st(32'h400 + 32'(4 * i), 32'hA0A0A000 + 32'(i), 3'd4); #1;
      check_eq("full_ready", bus.st_ready, i < 4);
      tick();
    end
    clr_in(); #1;
    check_eq("full_count", bus.count, 4'd4);
    tick();
    for (int i = 0; i < 20; i++) begin
      clr_in(); bus.wr_grant = 1'b1; tick();
    end
    clr_in(); #1;
    check_eq("full_drained", bus.empty, 1'b1);
    tick();

    // IO halfword held off by a full UART buffer, then paced by the gap
    clr_in(); push_st(32'h30000, 32'h00004241, 3'd2); tick();
    for (int i = 0; i < 3; i++) begin
      clr_in(); bus.wr_grant = 1'b1; bus.io_buffer_full = 1'b1; #1;
      check_eq("io_held", bus.wr_req, 1'b0);
      tick();
    end
    clr_in(); bus.wr_grant = 1'b1; #1;
    check_eq("io_req0", bus.wr_req, 1'b1);
    check_eq("io_data0", bus.wr_data, 8'h41);
    tick();
    clr_in(); bus.wr_grant = 1'b1; #1;
    check_eq("io_gap", bus.wr_req, 1'b0);
    tick();
    clr_in(); bus.wr_grant = 1'b1; #1;
    check_eq("io_req1", bus.wr_req, 1'b1);
    check_eq("io_addr1", bus.wr_addr, 32'h30001);
    check_eq("io_data1", bus.wr_data, 8'h42);
    tick();
    clr_in(); tick();

    // Load overlap against a queued halfword at 0x200
    clr_in(); push_st(32'h200, 32'h00005566, 3'd2); tick();
    clr_in(); bus.ld_check = 1'b1; bus.ld_addr = 32'h1FE; bus.ld_len = 3'd4; #1;
    check_eq("ld_overlap", bus.ld_conflict, 1'b1);
    tick();
    clr_in(); bus.ld_check = 1'b1; bus.ld_addr = 32'h204; bus.ld_len = 3'd4; #1;
`ifdef LOAD_CONFLICT_EN
    check_eq("ld_disjoint", bus.ld_conflict, 1'b0);
`else
    check_eq("ld_disjoint", bus.ld_conflict, 1'b1);
`endif
    tick();
    for (int i = 0; i < 4; i++) begin
      clr_in(); bus.wr_grant = 1'b1; tick();
    end

    // RAM port busy holds the byte; reset mid-drain abandons the entry
    clr_in(); push_st(32'h300, 32'hAABBCCDD, 3'd4); tick();
    for (int i = 0; i < 2; i++) begin
      clr_in(); bus.wr_grant = 1'b1; bus.rd_busy = 1'b1; #1;
      check_eq("busy_req", bus.wr_req, 1'b0);
      tick();
    end
    clr_in(); bus.wr_grant = 1'b1; #1;
    check_eq("busy_addr0", bus.wr_addr, 32'h300);
    check_eq("busy_data0", bus.wr_data, 8'hDD);
    tick();
    clr_in(); bus.wr_grant = 1'b1; #1;
    check_eq("busy_addr1", bus.wr_addr, 32'h301);
    check_eq("busy_data1", bus.wr_data, 8'hCC);
    tick();
    clr_in(); rst = 1'b1; bus.wr_grant = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      clr_in(); bus.wr_grant = 1'b1; #1;
      check_eq("post_rst_req", bus.wr_req, 1'b0);
      check_eq("post_rst_empty", bus.empty, 1'b1);
      tick();
    end

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] base;
      clr_in();
      rst = ($urandom_range(0, 299) == 0);
      base = ($urandom_range(0, 3) == 0) ? 32'h30000 : 32'h100;
      bus.st_valid       = $urandom_range(0, 1);
      bus.st_addr        = base + 32'($urandom_range(0, 15));
      bus.st_data        = $urandom;
      bus.st_len         = 3'($urandom_range(0, 7));
      bus.ld_check       = $urandom_range(0, 1);
      bus.ld_addr        = base + 32'($urandom_range(0, 19));
      case ($urandom_range(0, 2))
        0:       bus.ld_len = 3'd1;
        1:       bus.ld_len = 3'd2;
        default: bus.ld_len = 3'd4;
      endcase
      bus.rd_busy        = ($urandom_range(0, 3) == 0);
      bus.io_buffer_full = ($urandom_range(0, 9) < 3);
      bus.wr_grant       = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
